// File: rtl/amp_regler_agc_pkg.sv
// Shared types and helpers for the adaptive I/Q amplitude controller.
package amp_regler_agc_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_TRACK   = 2'd1,
    ST_HOLD    = 2'd2
  } agc_state_e;

  // Symmetric saturation bounds for a w-bit signed sample; -2**(w-1) is never produced.
  function automatic int sat_pos(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_neg(input int unsigned w);
    return -((1 << (w - 1)) - 1);
  endfunction

endpackage

// File: rtl/amp_regler_agc_mag_est.sv
// Magnitude approximation (max + min/2) and fixed-length window averager on gained samples.
module amp_regler_agc_mag_est
  import amp_regler_agc_pkg::*;
#(
  parameter int unsigned W        = 8,
  parameter int unsigned LOG2_WIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_valid,
  input  logic signed [W-1:0] i_real,
  input  logic signed [W-1:0] i_imag,
  output logic [W:0]          o_avg,
  output logic                o_win_done
);

  localparam int unsigned AW = W + 1 + LOG2_WIN;

  logic [W-1:0]        w_abs_re;
  logic [W-1:0]        w_abs_im;
  logic [W-1:0]        w_max;
  logic [W-1:0]        w_min;
  logic [W:0]          w_mag;
  logic [AW-1:0]       w_sum;
  logic [AW-1:0]       r_acc;
  logic [LOG2_WIN-1:0] r_cnt;
  logic [W:0]          r_avg;
  logic                r_win_done;

  assign w_abs_re = i_real[W-1] ? W'(-i_real) : W'(i_real);
  assign w_abs_im = i_imag[W-1] ? W'(-i_imag) : W'(i_imag);
  assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
  assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
  assign w_mag    = {1'b0, w_max} + (W+1)'(w_min >> 1);
  assign w_sum    = r_acc + AW'(w_mag);

  // Window closes on the 2**LOG2_WIN-th valid sample; the sample itself is included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_avg      <= '0;
      r_win_done <= 1'b0;
    end else if (i_clr) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_win_done <= 1'b0;
    end else begin
      r_win_done <= 1'b0;
      if (i_valid) begin
        if (r_cnt == '1) begin
          r_acc      <= '0;
          r_cnt      <= '0;
          r_avg      <= (W+1)'(w_sum >> LOG2_WIN);
          r_win_done <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + LOG2_WIN'(1);
        end
      end
    end
  end

  assign o_avg      = r_avg;
  assign o_win_done = r_win_done;

endmodule

// File: rtl/amp_regler_agc.sv
// Adaptive-gain I/Q amplitude controller: 2-stage scaling pipeline, gain loop FSM and lock detect.
module amp_regler_agc
  import amp_regler_agc_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned GW         = 12,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned LOG2_WIN   = 4,
  parameter int unsigned GAIN_INIT  = 256,
  parameter int unsigned GAIN_MIN   = 16,
  parameter int unsigned GAIN_MAX   = 4095,
  parameter int unsigned SHIFT_FAST = 1,
  parameter int unsigned SHIFT_SLOW = 4,
  parameter int unsigned LOCK_TOL   = 2,
  parameter int unsigned LOCK_WIN   = 4,
  parameter int unsigned UNLOCK_TOL = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] real_i,
  input  logic signed [W-1:0] imag_i,
  input  logic                valid_i,
  input  logic [W-1:0]        target_i,
  input  logic                freeze_i,
  input  logic                gain_load_i,
  input  logic [GW-1:0]       gain_val_i,
  output logic signed [W-1:0] real_o,
  output logic signed [W-1:0] imag_o,
  output logic                valid_o,
  output logic [GW-1:0]       gain_o,
  output logic                lock_o
);

  localparam int unsigned PW  = W + GW + 1;
  localparam int unsigned YW  = PW - FRAC;
  localparam int unsigned SW  = ((GW > W + 2) ? GW : W + 2) + 2;
  localparam int unsigned LCW = $clog2(LOCK_WIN + 1);

  localparam logic signed [PW-1:0] C_ROUND  = PW'(2 ** (FRAC - 1));
  localparam logic signed [YW-1:0] C_YMAX   = YW'(sat_pos(W));
  localparam logic signed [YW-1:0] C_YMIN   = YW'(sat_neg(W));
  localparam logic signed [SW-1:0] C_GMIN_S = SW'(GAIN_MIN);
  localparam logic signed [SW-1:0] C_GMAX_S = SW'(GAIN_MAX);
  localparam logic [GW-1:0]        C_GMIN   = GW'(GAIN_MIN);
  localparam logic [GW-1:0]        C_GMAX   = GW'(GAIN_MAX);
  localparam logic [GW-1:0]        C_GINIT  = GW'(GAIN_INIT);
  localparam logic [W+1:0]         C_LTOL   = (W+2)'(LOCK_TOL);
  localparam logic [W+1:0]         C_UTOL   = (W+2)'(UNLOCK_TOL);

  agc_state_e         r_state;
  logic [GW-1:0]      r_gain;
  logic               r_lock;
  logic [LCW-1:0]     r_lock_cnt;

  logic signed [PW-1:0] r_p_re;
  logic signed [PW-1:0] r_p_im;
  logic                 r_v1;
  logic signed [W-1:0]  r_re;
  logic signed [W-1:0]  r_im;
  logic                 r_v2;

  logic signed [GW:0]   w_gain_s;
  logic signed [PW-1:0] w_prod_re;
  logic signed [PW-1:0] w_prod_im;
  logic signed [PW-1:0] w_rnd_re;
  logic signed [PW-1:0] w_rnd_im;
  logic signed [YW-1:0] w_y_re;
  logic signed [YW-1:0] w_y_im;

  logic [W:0]           w_avg;
  logic                 w_win_done;
  logic                 w_mag_clr;
  logic signed [W+1:0]  w_err;
  logic signed [W+1:0]  w_step;
  logic [W+1:0]         w_err_abs;
  logic                 w_in_tol;
  logic                 w_out_tol;
  logic signed [SW-1:0] w_gain_sum;
  logic [GW-1:0]        w_gain_upd;
  logic [GW-1:0]        w_gain_load;

  function automatic logic signed [W-1:0] sat_y(input logic signed [YW-1:0] y);
    if (y > C_YMAX) begin
      return W'(C_YMAX);
    end else if (y < C_YMIN) begin
      return W'(C_YMIN);
    end else begin
      return W'(y);
    end
  endfunction

  // Stage 1 multiplies by the gain register as it stands, so an update is seen by the next sample.
  assign w_gain_s  = $signed({1'b0, r_gain});
  assign w_prod_re = PW'(real_i) * PW'(w_gain_s);
  assign w_prod_im = PW'(imag_i) * PW'(w_gain_s);
  assign w_rnd_re  = r_p_re + C_ROUND;
  assign w_rnd_im  = r_p_im + C_ROUND;
  assign w_y_re    = YW'(w_rnd_re >>> FRAC);
  assign w_y_im    = YW'(w_rnd_im >>> FRAC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_re <= '0;
      r_p_im <= '0;
      r_v1   <= 1'b0;
      r_re   <= '0;
      r_im   <= '0;
      r_v2   <= 1'b0;
    end else begin
      r_p_re <= w_prod_re;
      r_p_im <= w_prod_im;
      r_v1   <= valid_i;
      r_re   <= sat_y(w_y_re);
      r_im   <= sat_y(w_y_im);
      r_v2   <= r_v1;
    end
  end

  // Window contents are discarded whenever the loop is frozen or reloaded.
  assign w_mag_clr = gain_load_i | freeze_i | (r_state == ST_HOLD);

  amp_regler_agc_mag_est #(
    .W        (W),
    .LOG2_WIN (LOG2_WIN)
  ) u_mag_est (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_mag_clr),
    .i_valid    (r_v2),
    .i_real     (r_re),
    .i_imag     (r_im),
    .o_avg      (w_avg),
    .o_win_done (w_win_done)
  );

  assign w_err      = $signed({2'b00, target_i}) - $signed({1'b0, w_avg});
  assign w_err_abs  = w_err[W+1] ? (W+2)'(-w_err) : (W+2)'(w_err);
  assign w_in_tol   = (w_err_abs <= C_LTOL);
  assign w_out_tol  = (w_err_abs > C_UTOL);
  assign w_step     = (r_state == ST_TRACK) ? (w_err >>> SHIFT_SLOW) : (w_err >>> SHIFT_FAST);
  assign w_gain_sum = SW'($signed({2'b00, r_gain})) + SW'(w_step);

  always_comb begin
    w_gain_upd  = GW'(w_gain_sum);
    w_gain_load = gain_val_i;
    if (w_gain_sum < C_GMIN_S) begin
      w_gain_upd = C_GMIN;
    end else if (w_gain_sum > C_GMAX_S) begin
      w_gain_upd = C_GMAX;
    end
    if (gain_val_i < C_GMIN) begin
      w_gain_load = C_GMIN;
    end else if (gain_val_i > C_GMAX) begin
      w_gain_load = C_GMAX;
    end
  end

  // Loop FSM: preload beats freeze, freeze beats a pending window update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_ACQUIRE;
      r_gain     <= C_GINIT;
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
    end else if (gain_load_i) begin
      r_gain     <= w_gain_load;
      r_lock     <= 1'b0;
      r_lock_cnt <= '0;
      r_state    <= freeze_i ? ST_HOLD : ST_ACQUIRE;
    end else if (freeze_i) begin
      r_state <= ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_state <= r_lock ? ST_TRACK : ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (w_win_done) begin
            r_gain <= w_gain_upd;
            if (!w_in_tol) begin
              r_lock_cnt <= '0;
            end else if (r_lock_cnt == LCW'(LOCK_WIN - 1)) begin
              r_lock_cnt <= '0;
              r_lock     <= 1'b1;
              r_state    <= ST_TRACK;
            end else begin
              r_lock_cnt <= r_lock_cnt + LCW'(1);
            end
          end
        end
        ST_TRACK: begin
          if (w_win_done) begin
            r_gain <= w_gain_upd;
            if (w_out_tol) begin
              r_lock     <= 1'b0;
              r_lock_cnt <= '0;
              r_state    <= ST_ACQUIRE;
            end
          end
        end
        default: begin
          r_state <= ST_ACQUIRE;
        end
      endcase
    end
  end

  assign real_o  = r_re;
  assign imag_o  = r_im;
  assign valid_o = r_v2;
  assign gain_o  = r_gain;
  assign lock_o  = r_lock;

endmodule

// File: tb/tb_amp_regler_agc.sv
// Directed self-checking bench for amp_regler_agc at default parameters.
module tb_amp_regler_agc;

  logic              clk;
  logic              rst;
  logic signed [7:0] real_i;
  logic signed [7:0] imag_i;
  logic              valid_i;
  logic [7:0]        target_i;
  logic              freeze_i;
  logic              gain_load_i;
  logic [11:0]       gain_val_i;
  logic signed [7:0] real_o;
  logic signed [7:0] imag_o;
  logic              valid_o;
  logic [11:0]       gain_o;
  logic              lock_o;

  int checks;
  int failures;

  amp_regler_agc dut (
    .clk         (clk),
    .rst         (rst),
    .real_i      (real_i),
    .imag_i      (imag_i),
    .valid_i     (valid_i),
    .target_i    (target_i),
    .freeze_i    (freeze_i),
    .gain_load_i (gain_load_i),
    .gain_val_i  (gain_val_i),
    .real_o      (real_o),
    .imag_o      (imag_o),
    .valid_o     (valid_o),
    .gain_o      (gain_o),
    .lock_o      (lock_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [7:0] re, input logic signed [7:0] im);
    real_i  = re;
    imag_i  = im;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic stream(input int n);
    repeat (n) drive(8'sd11, -8'sd5);
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic load_gain(input logic [11:0] v);
    gain_val_i  = v;
    gain_load_i = 1'b1;
    tick();
    gain_load_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %0d expected 0", valid_o); end
    checks++; if (real_o !== 8'sd0 || imag_o !== 8'sd0) begin failures++; $display("FAIL rst_data: got %0d/%0d expected 0/0", real_o, imag_o); end
    checks++; if (gain_o !== 12'd256) begin failures++; $display("FAIL rst_gain: got %0d expected 256", gain_o); end
    checks++; if (lock_o !== 1'b0) begin failures++; $display("FAIL rst_lock: got %0d expected 0", lock_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_freeze_passthrough();
    target_i = 8'd45;
    freeze_i = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(8'sd11, -8'sd5);
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL frz_gap_valid[%0d]: got %0d expected 0", i, valid_o); end
      tick();
      checks++; if (valid_o !== 1'b1 || real_o !== 8'sd11 || imag_o !== -8'sd5) begin
        failures++; $display("FAIL frz_out[%0d]: got v=%0d %0d/%0d expected v=1 11/-5", i, valid_o, real_o, imag_o);
      end
    end
    drain();
    checks++; if (gain_o !== 12'd256) begin failures++; $display("FAIL frz_gain: got %0d expected 256", gain_o); end
    freeze_i = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_saturation();
    load_gain(12'd4095);
    checks++; if (gain_o !== 12'd4095) begin failures++; $display("FAIL sat_load: got %0d expected 4095", gain_o); end
    real_i = 8'sd100;  imag_i = -8'sd100; valid_i = 1'b1;
    tick();
    real_i = -8'sd128; imag_i = 8'sd127;
    tick();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || real_o !== 8'sd127 || imag_o !== -8'sd127) begin
      failures++; $display("FAIL sat_a: got v=%0d %0d/%0d expected v=1 127/-127", valid_o, real_o, imag_o);
    end
    tick();
    checks++; if (valid_o !== 1'b1 || real_o !== -8'sd127 || imag_o !== 8'sd127) begin
      failures++; $display("FAIL sat_b: got v=%0d %0d/%0d expected v=1 -127/127", valid_o, real_o, imag_o);
    end
    drain();
    load_gain(12'd256);
  endtask

  task automatic test_window_update();
    target_i = 8'd45;
    stream(15);
    drain();
    checks++; if (gain_o !== 12'd256) begin failures++; $display("FAIL win_partial: got %0d expected 256", gain_o); end
    drive(8'sd11, -8'sd5);
    for (int i = 0; i < 8 && gain_o == 12'd256; i++) tick();
    checks++; if (gain_o !== 12'd272) begin failures++; $display("FAIL win_gain: got %0d expected 272", gain_o); end
    drive(8'sd11, -8'sd5);
    tick();
    checks++; if (valid_o !== 1'b1 || real_o !== 8'sd12 || imag_o !== -8'sd5) begin
      failures++; $display("FAIL win_newgain_out: got v=%0d %0d/%0d expected v=1 12/-5", valid_o, real_o, imag_o);
    end
    drain();
  endtask

  task automatic test_lock();
    load_gain(12'd256);
    target_i = 8'd13;
    stream(48);
    drain();
    checks++; if (lock_o !== 1'b0) begin failures++; $display("FAIL lock_early: got %0d expected 0", lock_o); end
    stream(16);
    drain();
    checks++; if (lock_o !== 1'b1) begin failures++; $display("FAIL lock_set: got %0d expected 1", lock_o); end
    checks++; if (gain_o !== 12'd256) begin failures++; $display("FAIL lock_gain: got %0d expected 256", gain_o); end
    target_i = 8'd40;
    stream(16);
    drain();
    checks++; if (lock_o !== 1'b0) begin failures++; $display("FAIL unlock: got %0d expected 0", lock_o); end
    checks++; if (gain_o !== 12'd257) begin failures++; $display("FAIL unlock_slow_step: got %0d expected 257", gain_o); end
    stream(16);
    drain();
    checks++; if (gain_o !== 12'd270) begin failures++; $display("FAIL reacq_fast_step: got %0d expected 270", gain_o); end
  endtask

  task automatic test_freeze_window();
    load_gain(12'd256);
    target_i = 8'd45;
    stream(15);
    drain();
    freeze_i = 1'b1;
    drive(8'sd11, -8'sd5);
    repeat (4) tick();
    checks++; if (gain_o !== 12'd256) begin failures++; $display("FAIL fw_hold_gain: got %0d expected 256", gain_o); end
    freeze_i = 1'b0;
    repeat (2) tick();
    stream(15);
    drain();
    checks++; if (gain_o !== 12'd256) begin failures++; $display("FAIL fw_fresh_partial: got %0d expected 256", gain_o); end
    stream(1);
    drain();
    checks++; if (gain_o !== 12'd272) begin failures++; $display("FAIL fw_fresh_done: got %0d expected 272", gain_o); end
  endtask

  task automatic test_async_reset();
    load_gain(12'd300);
    checks++; if (gain_o !== 12'd300) begin failures++; $display("FAIL ar_preload: got %0d expected 300", gain_o); end
    real_i = 8'sd11; imag_i = -8'sd5; valid_i = 1'b1;
    repeat (3) tick();
    checks++; if (valid_o !== 1'b1 || real_o !== 8'sd13) begin failures++; $display("FAIL ar_pre_out: got v=%0d %0d expected v=1 13", valid_o, real_o); end
    #3;
    rst = 1'b0;
    valid_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b0 || real_o !== 8'sd0 || imag_o !== 8'sd0) begin
      failures++; $display("FAIL ar_immediate: got v=%0d %0d/%0d expected v=0 0/0", valid_o, real_o, imag_o);
    end
    checks++; if (gain_o !== 12'd256 || lock_o !== 1'b0) begin failures++; $display("FAIL ar_gain: got %0d lock %0d expected 256 lock 0", gain_o, lock_o); end
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL ar_no_valid[%0d]: got %0d expected 0", i, valid_o); end
    end
    load_gain(12'd5);
    checks++; if (gain_o !== 12'd16) begin failures++; $display("FAIL ar_clamp_min: got %0d expected 16", gain_o); end
    load_gain(12'd4095);
    load_gain(12'd3000);
    checks++; if (gain_o !== 12'd3000) begin failures++; $display("FAIL ar_load_mid: got %0d expected 3000", gain_o); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    real_i      = '0;
    imag_i      = '0;
    valid_i     = 1'b0;
    target_i    = '0;
    freeze_i    = 1'b0;
    gain_load_i = 1'b0;
    gain_val_i  = '0;
    test_reset();
    test_freeze_passthrough();
    test_saturation();
    test_window_update();
    test_lock();
    test_freeze_window();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
